// File: rtl/rv_alu_mc.sv
// Multi-cycle execute ALU: 1-cycle integer ops, MUL_LAT-cycle multiply, radix-2 divide (XLEN+1 cycles).
// One op in flight; req_ready only when idle, result held in RESP until rsp_ready.
`timescale 1ns/1ps

package pkg_rv_decode;
  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_S2, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_OR, ALU_AND,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
    ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_t;
endpackage

module rv_alu_mc
  import pkg_rv_decode::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_LAT  = 3,
  parameter int DIV_FAST = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  alu_t            req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, RESP} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] res, rem, quo, dvs;
  logic            neg, is_rem, spec;

  logic            is_mul, is_div, div_signed, div_rem, sa, sb;
  logic            div_zero, div_ovf, div_special;
  logic [XLEN-1:0] abs_a, abs_b, div_spec_res, alu_res, mul_res;
  logic [2*XLEN-1:0] mul_a, mul_b, prod;
  logic [SHW-1:0]  shamt;

  logic [XLEN:0]   trial;
  logic [XLEN-1:0] rem_nxt, quo_nxt, div_val;

  always_comb begin
    is_mul     = req_op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
    is_div     = req_op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    div_signed = (req_op == ALU_DIV) || (req_op == ALU_REM);
    div_rem    = (req_op == ALU_REM) || (req_op == ALU_REMU);
    sa         = div_signed & req_a[XLEN-1];
    sb         = div_signed & req_b[XLEN-1];
    abs_a      = sa ? -req_a : req_a;
    abs_b      = sb ? -req_b : req_b;
    div_zero   = (req_b == '0);
    div_ovf    = div_signed && (req_a == {1'b1, {(XLEN-1){1'b0}}}) && (req_b == '1);
    div_special = div_zero | div_ovf;
    if (div_zero) div_spec_res = div_rem ? req_a : '1;
    else          div_spec_res = div_rem ? '0 : req_a;
  end

  // Operands widened to 2*XLEN; the low 2*XLEN product bits match the (XLEN+1)-bit signed product.
  always_comb begin
    mul_a   = {{XLEN{(req_op != ALU_MULHU) & req_a[XLEN-1]}}, req_a};
    mul_b   = {{XLEN{((req_op == ALU_MUL) || (req_op == ALU_MULH)) & req_b[XLEN-1]}}, req_b};
    prod    = mul_a * mul_b;
    mul_res = (req_op == ALU_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    shamt   = req_b[SHW-1:0];
    alu_res = '0;
    case (req_op)
      ALU_ADD:  alu_res = req_a + req_b;
      ALU_SUB:  alu_res = req_a - req_b;
      ALU_S2:   alu_res = req_b;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(req_a) < $signed(req_b)};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, req_a < req_b};
      ALU_XOR:  alu_res = req_a ^ req_b;
      ALU_OR:   alu_res = req_a | req_b;
      ALU_AND:  alu_res = req_a & req_b;
      ALU_SLL:  alu_res = req_a << shamt;
      ALU_SRL:  alu_res = req_a >> shamt;
      ALU_SRA:  alu_res = $signed(req_a) >>> shamt;
      default:  alu_res = '0;
    endcase
  end

  // One restoring shift-subtract step; quo shifts dividend bits out and quotient bits in.
  always_comb begin
    trial = {rem, quo[XLEN-1]} - {1'b0, dvs};
    if (trial[XLEN]) begin
      rem_nxt = {rem[XLEN-2:0], quo[XLEN-1]};
      quo_nxt = {quo[XLEN-2:0], 1'b0};
    end else begin
      rem_nxt = trial[XLEN-1:0];
      quo_nxt = {quo[XLEN-2:0], 1'b1};
    end
    div_val = is_rem ? rem_nxt : quo_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    busy      = (state != IDLE);
    rsp_data  = res;
    case (state)
      IDLE: if (req_valid) begin
        if (is_mul)      state_nxt = (MUL_LAT == 1) ? RESP : MUL;
        else if (is_div) state_nxt = ((DIV_FAST != 0) && div_special) ? RESP : DIV;
        else             state_nxt = RESP;
      end
      MUL:  if (cnt == CW'(1)) state_nxt = RESP;
      DIV:  if (cnt == CW'(XLEN-1)) state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      res    <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      neg    <= 1'b0;
      is_rem <= 1'b0;
      spec   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          if (is_mul) begin
            res <= mul_res;
            cnt <= CW'(MUL_LAT-1);
          end else if (is_div) begin
            res    <= div_spec_res;
            spec   <= div_special;
            rem    <= '0;
            quo    <= abs_a;
            dvs    <= abs_b;
            is_rem <= div_rem;
            neg    <= div_rem ? sa : (sa ^ sb);
            cnt    <= '0;
          end else begin
            res <= alu_res;
          end
        end
        MUL: cnt <= cnt - 1'b1;
        DIV: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + 1'b1;
          // Special-case result was preloaded at accept and is kept.
          if ((cnt == CW'(XLEN-1)) && !spec) res <= neg ? -div_val : div_val;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_alu_mc.sv
// Bench for rv_alu_mc: three instances (32-bit fast div, 32-bit slow div, 64-bit) behind one driver.
`timescale 1ns/1ps

module tb_rv_alu_mc;
  import pkg_rv_decode::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  sel = 2'd0;
  logic        req_valid = 1'b0;
  logic        rsp_ready = 1'b0;
  alu_t        req_op = ALU_ADD;
  logic [63:0] req_a = '0, req_b = '0;

  logic [2:0]  rqr, rsv, bsy;
  logic [31:0] d0, d1;
  logic [63:0] d2;
  logic        rsp_valid_m, req_ready_m, busy_m;
  logic [63:0] rsp_data_m;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    logic [63:0] dat;
    int          lat;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  rv_alu_mc #(.XLEN(32), .MUL_LAT(3), .DIV_FAST(1)) u_fast32 (
    .clk(clk), .reset(reset), .req_valid(req_valid && sel == 2'd0), .req_ready(rqr[0]),
    .req_op(req_op), .req_a(req_a[31:0]), .req_b(req_b[31:0]), .rsp_valid(rsv[0]),
    .rsp_ready(rsp_ready), .rsp_data(d0), .busy(bsy[0]));

  rv_alu_mc #(.XLEN(32), .MUL_LAT(3), .DIV_FAST(0)) u_slow32 (
    .clk(clk), .reset(reset), .req_valid(req_valid && sel == 2'd1), .req_ready(rqr[1]),
    .req_op(req_op), .req_a(req_a[31:0]), .req_b(req_b[31:0]), .rsp_valid(rsv[1]),
    .rsp_ready(rsp_ready), .rsp_data(d1), .busy(bsy[1]));

  rv_alu_mc #(.XLEN(64), .MUL_LAT(3), .DIV_FAST(1)) u_fast64 (
    .clk(clk), .reset(reset), .req_valid(req_valid && sel == 2'd2), .req_ready(rqr[2]),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsv[2]),
    .rsp_ready(rsp_ready), .rsp_data(d2), .busy(bsy[2]));

  always_comb begin
    rsp_valid_m = rsv[sel];
    req_ready_m = rqr[sel];
    busy_m      = bsy[sel];
    case (sel)
      2'd0:    rsp_data_m = {32'b0, d0};
      2'd1:    rsp_data_m = {32'b0, d1};
      default: rsp_data_m = d2;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input alu_t op, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input int lat, input string tag);
    @(negedge clk);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    exp_q.push_back('{tag, exp, lat});
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic release_rsp();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  // Called #1 after the accept edge; latency 1 means rsp_valid is already up.
  task automatic collect();
    exp_t e;
    int   cyc = 1;
    while (!rsp_valid_m && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 64'(exp_q.size()), 64'd1);
    end else begin
      e = exp_q.pop_front();
      check({e.tag, "_lat"}, 64'(cyc), 64'(e.lat));
      check({e.tag, "_dat"}, rsp_data_m, e.dat);
    end
    release_rsp();
    check("idle_after_rsp", {62'b0, busy_m, req_ready_m}, 64'b01);
  endtask

  task automatic run(input logic [1:0] s, input alu_t op, input logic [63:0] a,
                     input logic [63:0] b, input logic [63:0] exp, input int lat,
                     input string tag);
    sel = s;
    issue(op, a, b, exp, lat, tag);
    collect();
  endtask

  initial begin
    alu_t bad_op;
    int   seen;
    bad_op = alu_t'(5'd31);

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      sel = 2'(i);
      #0;
      check("rst_req_ready", 64'(req_ready_m), 64'd1);
      check("rst_rsp_valid", 64'(rsp_valid_m), 64'd0);
      check("rst_busy", 64'(busy_m), 64'd0);
      check("rst_data", rsp_data_m, 64'd0);
    end
    @(negedge clk);
    reset = 1'b0;

    run(0, ALU_ADD,  64'hFFFFFFFF, 64'd1,          64'd0,          1, "add_wrap");
    run(0, ALU_SUB,  64'd3,        64'd5,          64'hFFFFFFFE,   1, "sub");
    run(0, ALU_S2,   64'd1,        64'h12345678,   64'h12345678,   1, "s2");
    run(0, ALU_SRA,  64'h80000000, 64'h21,         64'hC0000000,   1, "sra");
    run(0, ALU_SRL,  64'h80000000, 64'd4,          64'h08000000,   1, "srl");
    run(0, ALU_SLL,  64'd1,        64'h3F,         64'h80000000,   1, "sll");
    run(0, ALU_SLT,  64'hFFFFFFFF, 64'd0,          64'd1,          1, "slt");
    run(0, ALU_SLTU, 64'hFFFFFFFF, 64'd0,          64'd0,          1, "sltu");
    run(0, ALU_XOR,  64'hF0F0F0F0, 64'hFF00FF00,   64'h0FF00FF0,   1, "xor");
    run(0, ALU_OR,   64'hF0F0F0F0, 64'hFF00FF00,   64'hFFF0FFF0,   1, "or");
    run(0, ALU_AND,  64'hF0F0F0F0, 64'hFF00FF00,   64'hF000F000,   1, "and");
    run(0, bad_op,   64'h1234,     64'h5678,       64'd0,          1, "bad_op");

    run(0, ALU_MULH,   64'h80000000, 64'h80000000, 64'h40000000,   3, "mulh");
    run(0, ALU_MULHSU, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF,   3, "mulhsu");
    run(0, ALU_MULHU,  64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE,   3, "mulhu");
    run(0, ALU_MUL,    64'd7,        64'hFFFFFFFD, 64'hFFFFFFEB,   3, "mul");

    run(0, ALU_DIV,  64'hFFFFFFF9, 64'd2,          64'hFFFFFFFD,  33, "div_neg");
    run(0, ALU_REM,  64'hFFFFFFF9, 64'd2,          64'hFFFFFFFF,  33, "rem_neg");
    run(0, ALU_DIV,  64'd7,        64'hFFFFFFFE,   64'hFFFFFFFD,  33, "div_negb");
    run(0, ALU_REM,  64'd7,        64'hFFFFFFFE,   64'd1,         33, "rem_negb");
    run(0, ALU_DIVU, 64'd100,      64'd7,          64'd14,        33, "divu");
    run(0, ALU_REMU, 64'd100,      64'd7,          64'd2,         33, "remu");
    run(0, ALU_DIV,  64'd5,        64'd0,          64'hFFFFFFFF,   1, "fdiv_z");
    run(0, ALU_REM,  64'd5,        64'd0,          64'd5,          1, "frem_z");
    run(0, ALU_DIVU, 64'd5,        64'd0,          64'hFFFFFFFF,   1, "fdivu_z");
    run(0, ALU_DIV,  64'h80000000, 64'hFFFFFFFF,   64'h80000000,   1, "fdiv_ovf");
    run(0, ALU_REM,  64'h80000000, 64'hFFFFFFFF,   64'd0,          1, "frem_ovf");

    run(1, ALU_DIV,  64'd5,        64'd0,          64'hFFFFFFFF,  33, "sdiv_z");
    run(1, ALU_REM,  64'd5,        64'd0,          64'd5,         33, "srem_z");
    run(1, ALU_REM,  64'hFFFFFFFB, 64'd0,          64'hFFFFFFFB,  33, "srem_zneg");
    run(1, ALU_DIV,  64'h80000000, 64'hFFFFFFFF,   64'h80000000,  33, "sdiv_ovf");
    run(1, ALU_REM,  64'h80000000, 64'hFFFFFFFF,   64'd0,         33, "srem_ovf");

    run(2, ALU_SLL,   64'd1,  64'd63, 64'h8000000000000000,  1, "x64_sll");
    run(2, ALU_DIVU,  64'hFFFFFFFFFFFFFFFF, 64'd3, 64'h5555555555555555, 65, "x64_divu");
    run(2, ALU_DIV,   64'hFFFFFFFFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFD, 65, "x64_div");
    run(2, ALU_MULHU, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE, 3, "x64_mulhu");

    // Backpressure: result held while a second request waits at the input.
    sel = 2'd0;
    issue(ALU_ADD, 64'd10, 64'd20, 64'd30, 1, "bp_first");
    check("bp_valid0", 64'(rsp_valid_m), 64'd1);
    @(negedge clk);
    req_op = ALU_ADD; req_a = 64'd1; req_b = 64'd1; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", 64'(rsp_valid_m), 64'd1);
      check("bp_hold_data", rsp_data_m, 64'd30);
      check("bp_hold_rdy", 64'(req_ready_m), 64'd0);
    end
    begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.tag, "_dat"}, rsp_data_m, e.dat);
    end
    release_rsp();
    check("bp_after_hs_valid", 64'(rsp_valid_m), 64'd0);
    check("bp_after_hs_rdy", 64'(req_ready_m), 64'd1);
    exp_q.push_back('{"bp_second", 64'd2, 1});
    @(posedge clk); #1;
    req_valid = 1'b0;
    collect();

    // Reset during the tenth divide iteration aborts the operation.
    sel = 2'd0;
    @(negedge clk);
    req_op = ALU_DIVU; req_a = 64'd100; req_b = 64'd7; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_rdy", 64'(req_ready_m), 64'd1);
    check("rst_mid_busy", 64'(busy_m), 64'd0);
    check("rst_mid_valid", 64'(rsp_valid_m), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (rsp_valid_m) seen++;
    end
    check("rst_no_rsp", 64'(seen), 64'd0);
    run(0, ALU_ADD, 64'd2, 64'd3, 64'd5, 1, "post_rst_add");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rv_alu_mc.md
Name: rv_alu_mc

Overview:
- Parametrised, registered, multi-cycle integer ALU; next generation of the core's execute-stage ALU.
- Width is generalised to XLEN. Integer and M-extension ops are handled behind a valid/ready request/response handshake.
- Multiply is an internal sequential pipeline; divide/remainder is an iterative radix-2 unit.
- Sits in the execute stage between the register-read operands and writeback. The pipeline stalls on req_ready/rsp_valid instead of a completion strobe.

Parameters:
- XLEN, 32, operand/result width (32 or 64).
- MUL_LAT, 3, cycles from request accept to rsp_valid for MUL/MULH/MULHSU/MULHU (range 1..4).
- DIV_FAST, 1, 1 = divide-by-zero and signed-overflow cases complete in 1 cycle; 0 = always full iteration.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_op  in  alu_t  operation code from pkg_rv_decode
- req_a  in  XLEN  operand rs1
- req_b  in  XLEN  operand rs2/immediate
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_data  out  XLEN  result
- busy  out  1  an operation is accepted and not yet consumed

Behaviour:
- Reset: state IDLE; req_ready=1, rsp_valid=0, rsp_data=0, busy=0; all internal counters and partials cleared. A reset asserted mid-operation aborts the operation; no response is ever produced for it.
- One operation in flight. A request is accepted on a cycle with req_valid & req_ready. Operands and op are registered on accept.
- FSM states: IDLE, MUL, DIV, RESP.
  - IDLE, accept, single-cycle op -> RESP. rsp_valid is asserted the next cycle (latency 1).
  - IDLE, accept, mul op -> MUL. Counter loaded with MUL_LAT-1. At count 0 -> RESP, so rsp_valid rises exactly MUL_LAT cycles after accept.
  - IDLE, accept, div op -> DIV. XLEN shift-subtract iterations, then one fix-up cycle (sign correction) -> RESP. rsp_valid rises at XLEN+1 cycles after accept.
  - RESP holds rsp_valid and rsp_data stable until rsp_ready. On handshake -> IDLE.
- req_ready is 1 only in IDLE. No same-cycle accept in RESP (no bypass). rsp_ready asserted while rsp_valid=0 is ignored.
- busy = (state != IDLE).
- Single-cycle ops:
  - ADD, SUB: modulo 2^XLEN.
  - S2: result = b.
  - SLT: signed compare, result 0/1. SLTU: unsigned compare, result 0/1.
  - XOR, OR, AND.
  - SLL, SRL, SRA: shift amount = b[log2(XLEN)-1:0]; upper bits of b ignored.
  - Unrecognised op: result 0, latency 1.
- Multiply:
  - Full 2*XLEN product computed from sign-extended (XLEN+1)-bit operands.
  - MUL returns low XLEN bits. MULH (s×s), MULHSU (s×u), MULHU (u×u) return high XLEN bits.
- Divide:
  - Iterate on magnitudes. Quotient sign = sa^sb; remainder sign = sa.
  - b==0: DIV/DIVU = all ones; REM/REMU = a.
  - DIV with a = most-negative and b = -1: quotient = a, REM = 0.
  - With DIV_FAST=1, both of these cases go to RESP after 1 cycle; otherwise after XLEN+1.
- Inputs are don't-care when not accepted. req_op/req_a/req_b changing during MUL/DIV have no effect.

Test Plan:
- XLEN=32: ADD a=0xFFFFFFFF, b=1 -> after 1 cycle rsp_data=0; SRA a=0x80000000, b=0x21 (shamt 1) -> 0xC0000000; SLT a=0xFFFFFFFF, b=0 -> 1; SLTU same operands -> 0.
- MUL_LAT=3: MULH a=0x80000000, b=0x80000000 -> rsp_valid exactly 3 cycles after accept, data 0x40000000. MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF. MUL 7×-3 -> 0xFFFFFFEB.
- DIV a=-7, b=2 -> 0xFFFFFFFD at 33 cycles. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU -> 2.
- DIV_FAST=1: DIV a=5, b=0 -> 0xFFFFFFFF after 1 cycle. REM a=5, b=0 -> 5. DIV a=0x80000000, b=-1 -> 0x80000000, REM -> 0, each after 1 cycle. Repeat with DIV_FAST=0 -> same data at 33 cycles.
- Backpressure: hold rsp_ready=0 for 5 cycles after ADD completes -> rsp_valid and data stable, req_ready=0 throughout. A new request with req_valid=1 is not accepted until the cycle after the rsp handshake.
- Reset during DIV at iteration 10 -> next cycle req_ready=1, busy=0, rsp_valid=0. A following ADD 2+3 returns 5 at latency 1.
- XLEN=64 regression: SLL a=1, b=63 -> 0x8000000000000000. DIVU 2^64-1 by 3 -> 0x5555555555555555 at 65 cycles.
